// File: rtl/jtag_bscan_pkg.sv
// rtl/jtag_bscan_pkg.sv - TAP state encoding and default opcodes for the user boundary-scan port
package jtag_bscan_pkg;

  // IEEE 1149.1 reference encoding for the 16 TAP states
  typedef enum logic [3:0] {
    ST_EXIT2_DR  = 4'h0,
    ST_EXIT1_DR  = 4'h1,
    ST_SHIFT_DR  = 4'h2,
    ST_PAUSE_DR  = 4'h3,
    ST_SEL_IR    = 4'h4,
    ST_UPDATE_DR = 4'h5,
    ST_CAP_DR    = 4'h6,
    ST_SEL_DR    = 4'h7,
    ST_EXIT2_IR  = 4'h8,
    ST_EXIT1_IR  = 4'h9,
    ST_SHIFT_IR  = 4'hA,
    ST_PAUSE_IR  = 4'hB,
    ST_RTI       = 4'hC,
    ST_UPDATE_IR = 4'hD,
    ST_CAP_IR    = 4'hE,
    ST_TLR       = 4'hF
  } tap_state_t;

  localparam int          IR_LEN_DEF    = 5;
  localparam logic [4:0]  OP_USER1_DEF  = 5'b00010;
  localparam logic [4:0]  OP_USER2_DEF  = 5'b00011;
  localparam logic [4:0]  OP_IDCODE_DEF = 5'b01001;
  localparam logic [31:0] IDCODE_DEF    = 32'h0000_0093;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - TMS-driven 16-state TAP controller with DR/TLR/RTI state decodes
module jtag_tap_fsm
  import jtag_bscan_pkg::*;
(
  input  logic       TCK,
  input  logic       RST_B,
  input  logic       TMS,
  output logic [3:0] state,
  output logic       shift_dr,
  output logic       capture_dr,
  output logic       update_dr,
  output logic       run_test,
  output logic       test_reset
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge TCK or negedge RST_B) begin
    if (!RST_B) state_q <= ST_TLR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:       state_d = TMS ? ST_TLR       : ST_RTI;
      ST_RTI:       state_d = TMS ? ST_SEL_DR    : ST_RTI;
      ST_SEL_DR:    state_d = TMS ? ST_SEL_IR    : ST_CAP_DR;
      ST_CAP_DR:    state_d = TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_SHIFT_DR:  state_d = TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_EXIT1_DR:  state_d = TMS ? ST_UPDATE_DR : ST_PAUSE_DR;
      ST_PAUSE_DR:  state_d = TMS ? ST_EXIT2_DR  : ST_PAUSE_DR;
      ST_EXIT2_DR:  state_d = TMS ? ST_UPDATE_DR : ST_SHIFT_DR;
      ST_UPDATE_DR: state_d = TMS ? ST_SEL_DR    : ST_RTI;
      ST_SEL_IR:    state_d = TMS ? ST_TLR       : ST_CAP_IR;
      ST_CAP_IR:    state_d = TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_SHIFT_IR:  state_d = TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_EXIT1_IR:  state_d = TMS ? ST_UPDATE_IR : ST_PAUSE_IR;
      ST_PAUSE_IR:  state_d = TMS ? ST_EXIT2_IR  : ST_PAUSE_IR;
      ST_EXIT2_IR:  state_d = TMS ? ST_UPDATE_IR : ST_SHIFT_IR;
      ST_UPDATE_IR: state_d = TMS ? ST_SEL_DR    : ST_RTI;
      default:      state_d = ST_TLR;
    endcase
  end

  always_comb begin
    state      = state_q;
    shift_dr   = (state_q == ST_SHIFT_DR);
    capture_dr = (state_q == ST_CAP_DR);
    update_dr  = (state_q == ST_UPDATE_DR);
    run_test   = (state_q == ST_RTI);
    test_reset = (state_q == ST_TLR);
  end

endmodule

// File: rtl/jtag_user_bscan.sv
// rtl/jtag_user_bscan.sv - JTAG TAP with USER1/USER2 user-chain port; BSCAN_IDCODE_EN adds the IDCODE register
module jtag_user_bscan
  import jtag_bscan_pkg::*;
#(
  parameter int                IR_LEN    = IR_LEN_DEF,
  parameter logic [IR_LEN-1:0] OP_USER1  = IR_LEN'(OP_USER1_DEF),
  parameter logic [IR_LEN-1:0] OP_USER2  = IR_LEN'(OP_USER2_DEF),
  parameter logic [IR_LEN-1:0] OP_BYPASS = '1
`ifdef BSCAN_IDCODE_EN
  ,
  parameter logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(OP_IDCODE_DEF),
  parameter logic [31:0]       IDCODE    = IDCODE_DEF
`endif
)
(
  input  logic TCK,
  input  logic RST_B,
  input  logic TMS,
  input  logic TDI,
  output logic TDO,
  output logic TDO_OE,
  output logic BTDI,
  output logic SEL1,
  output logic SEL2,
  output logic DRCK1,
  output logic DRCK2,
  output logic SHIFT,
  output logic CAPTURE,
  output logic UPDATE,
  output logic RUNTEST,
  output logic RESET,
  input  logic TDO1,
  input  logic TDO2
);

`ifdef BSCAN_IDCODE_EN
  localparam logic [IR_LEN-1:0] IR_RST = OP_IDCODE;
`else
  localparam logic [IR_LEN-1:0] IR_RST = OP_BYPASS;
`endif

  logic [3:0]        state_w;
  tap_state_t        state;
  logic [IR_LEN-1:0] ir;
  logic [IR_LEN-1:0] ir_sr;
  logic              bypass_q;
  logic              dr_tdo;
  logic              dr_clk_win;
  logic              drck_en1_q;
  logic              drck_en2_q;

  jtag_tap_fsm u_tap_fsm (
    .TCK        (TCK),
    .RST_B      (RST_B),
    .TMS        (TMS),
    .state      (state_w),
    .shift_dr   (SHIFT),
    .capture_dr (CAPTURE),
    .update_dr  (UPDATE),
    .run_test   (RUNTEST),
    .test_reset (RESET)
  );

  assign state      = tap_state_t'(state_w);
  assign SEL1       = (ir == OP_USER1);
  assign SEL2       = (ir == OP_USER2);
  assign BTDI       = TDI;
  assign TDO_OE     = (state == ST_SHIFT_IR) || (state == ST_SHIFT_DR);
  assign dr_clk_win = (state == ST_CAP_DR) || (state == ST_SHIFT_DR);

  // Shifters act on the rising edge of the state they are in
  always_ff @(posedge TCK or negedge RST_B) begin
    if (!RST_B) begin
      ir_sr    <= '0;
      bypass_q <= 1'b0;
    end else begin
      case (state)
        ST_TLR:      bypass_q <= 1'b0;
        ST_CAP_IR:   ir_sr    <= IR_LEN'(2'b01);
        ST_SHIFT_IR: ir_sr    <= {TDI, ir_sr[IR_LEN-1:1]};
        ST_CAP_DR:   bypass_q <= 1'b0;
        ST_SHIFT_DR: bypass_q <= TDI;
        default:     ;
      endcase
    end
  end

`ifdef BSCAN_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge TCK or negedge RST_B) begin
    if (!RST_B)                    id_sr <= '0;
    else if (state == ST_CAP_DR)   id_sr <= IDCODE;
    else if (state == ST_SHIFT_DR) id_sr <= {TDI, id_sr[31:1]};
  end
`endif

  always_comb begin
    dr_tdo = bypass_q;
    if (SEL1)      dr_tdo = TDO1;
    else if (SEL2) dr_tdo = TDO2;
`ifdef BSCAN_IDCODE_EN
    else if (ir == OP_IDCODE) dr_tdo = id_sr[0];
`endif
  end

  always_ff @(negedge TCK or negedge RST_B) begin
    if (!RST_B) begin
      ir         <= IR_RST;
      TDO        <= 1'b0;
      drck_en1_q <= 1'b0;
      drck_en2_q <= 1'b0;
    end else begin
      drck_en1_q <= dr_clk_win & SEL1;
      drck_en2_q <= dr_clk_win & SEL2;
      if (state == ST_TLR)            ir <= IR_RST;
      else if (state == ST_UPDATE_IR) ir <= ir_sr;
      if (state == ST_SHIFT_IR)       TDO <= ir_sr[0];
      else if (state == ST_SHIFT_DR)  TDO <= dr_tdo;
    end
  end

  // Falling-latched enable ANDed with the live window: the window closes while TCK is high, so DRCK never glitches low
  assign DRCK1 = TCK | ~(drck_en1_q & dr_clk_win & SEL1);
  assign DRCK2 = TCK | ~(drck_en2_q & dr_clk_win & SEL2);

endmodule

// File: tb/tb_jtag_user_bscan.sv
// tb/tb_jtag_user_bscan.sv - randomized transaction-level check of jtag_user_bscan against a scan-result model
module tb_jtag_user_bscan;

  localparam logic [4:0] OP_U1  = 5'b00010;
  localparam logic [4:0] OP_U2  = 5'b00011;
  localparam logic [4:0] OP_BYP = 5'b11111;
  localparam logic [4:0] OP_ID  = 5'b01001;
`ifdef BSCAN_IDCODE_EN
  localparam logic [4:0] IR_RST_M = OP_ID;
`else
  localparam logic [4:0] IR_RST_M = OP_BYP;
`endif

  logic TCK, RST_B, TMS, TDI, TDO1, TDO2;
  logic TDO, TDO_OE, BTDI, SEL1, SEL2, DRCK1, DRCK2;
  logic SHIFT, CAPTURE, UPDATE, RUNTEST, RESET;

  int n_chk = 0;
  int n_fail = 0;
  int upd_cnt = 0;
  int drck1_edges = 0;
  int drck2_edges = 0;
  logic [4:0] model_ir;

  jtag_user_bscan dut (
    .TCK(TCK), .RST_B(RST_B), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_OE(TDO_OE),
    .BTDI(BTDI), .SEL1(SEL1), .SEL2(SEL2), .DRCK1(DRCK1), .DRCK2(DRCK2),
    .SHIFT(SHIFT), .CAPTURE(CAPTURE), .UPDATE(UPDATE), .RUNTEST(RUNTEST),
    .RESET(RESET), .TDO1(TDO1), .TDO2(TDO2)
  );

  initial TCK = 1'b0;
  always #10 TCK = ~TCK;

  always @(posedge DRCK1) drck1_edges++;
  always @(posedge DRCK2) drck2_edges++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected DR scan result from the selected register's rules
  function automatic logic [63:0] dr_model(input logic [4:0] ir, input int n,
                                           input logic [63:0] din, input logic [63:0] usr);
    logic [95:0] full;
    logic [63:0] mask;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    if (ir == OP_U1)      full = {32'd0, usr};
    else if (ir == OP_U2) full = {32'd0, ~usr};
`ifdef BSCAN_IDCODE_EN
    else if (ir == OP_ID) full = {din, 32'h0000_0093};
`endif
    else                  full = {31'd0, din, 1'b0};
    return full[63:0] & mask;
  endfunction

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK); #2;
    @(negedge TCK); #2;
    if (UPDATE) upd_cnt++;
  endtask

  task automatic ir_scan(input logic [4:0] value);
    logic [4:0] cap;
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    cap[0] = TDO;
    for (int i = 0; i < 5; i++) begin
      step(i == 4, value[i]);
      if (i < 4) cap[i+1] = TDO;
    end
    step(1, 0);
    step(0, 0);
    model_ir = value;
    check("ir_capture", 64'(cap), 64'(5'b00001));
    check("sel1", 64'(SEL1), 64'(model_ir == OP_U1));
    check("sel2", 64'(SEL2), 64'(model_ir == OP_U2));
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] usr,
                         input int pause_at, output logic [63:0] dout);
    int e1, e2;
    dout = '0;
    upd_cnt = 0;
    e1 = drck1_edges;
    e2 = drck2_edges;
    step(1, 0);
    step(0, 0);
    check("capture", 64'(CAPTURE), 64'd1);
    TDO1 = usr[0];
    TDO2 = ~usr[0];
    step(0, 0);
    check("shift_oe", 64'({SHIFT, TDO_OE}), 64'd3);
    dout[0] = TDO;
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) begin
        TDO1 = usr[i+1];
        TDO2 = ~usr[i+1];
      end
      if (i == pause_at && i < n - 1) begin
        step(1, din[i]);
        step(0, 0);
        step(0, 0);
        check("pause_drck", 64'({DRCK1, DRCK2}), 64'd3);
        step(1, 0);
        step(0, 0);
      end else begin
        step(i == n - 1, din[i]);
        if (i == 0) check("btdi", 64'(BTDI), 64'(din[0]));
      end
      if (i < n - 1) dout[i+1] = TDO;
    end
    step(1, 0);
    step(0, 0);
    check("update_pulses", 64'(upd_cnt), 64'd1);
    check("rti_oe", 64'({RUNTEST, TDO_OE}), 64'd2);
    check("dr_out", dout, dr_model(model_ir, n, din, usr));
    check("drck1_edges", 64'(drck1_edges - e1), 64'((model_ir == OP_U1) ? n + 1 : 0));
    check("drck2_edges", 64'(drck2_edges - e2), 64'((model_ir == OP_U2) ? n + 1 : 0));
  endtask

  initial begin
    logic [63:0] din, usr, dout;
    logic [4:0]  op;
    int          n, pause_at;

    RST_B = 1'b1; TMS = 1'b1; TDI = 1'b0; TDO1 = 1'b0; TDO2 = 1'b0;
    #1 RST_B = 1'b0;
    #4;
    check("rst_reset", 64'(RESET), 64'd1);
    check("rst_sel", 64'({SEL1, SEL2}), 64'd0);
    check("rst_drck", 64'({DRCK1, DRCK2}), 64'd3);
    check("rst_misc", 64'({SHIFT, CAPTURE, UPDATE, RUNTEST, TDO_OE, TDO}), 64'd0);
    @(negedge TCK); #2;
    RST_B = 1'b1;
    step(0, 0);
    model_ir = IR_RST_M;
    check("rti_after_reset", 64'(RUNTEST), 64'd1);

    // 32-bit DR scan straight after reset
    din = {$urandom, $urandom};
    dr_scan(32, din, 64'd0, -1, dout);
`ifdef BSCAN_IDCODE_EN
    check("idcode_value", dout[31:0], 64'h0000_0093);
`else
    check("reset_bypass", dout[31:0], {32'd0, din[30:0], 1'b0});
`endif

    ir_scan(OP_BYP);
    dr_scan(4, 64'b1101, 64'd0, -1, dout);
    check("bypass_1011", dout[3:0], 64'b1010);

    ir_scan(OP_U1);
    usr = {$urandom, $urandom};
    dr_scan(8, {$urandom, $urandom}, usr, -1, dout);
    check("user1_stream", dout[7:0], 64'(usr[7:0]));

    ir_scan(OP_U2);
    dr_scan(8, {$urandom, $urandom}, ~64'hA5, -1, dout);
    check("user2_a5", dout[7:0], 64'hA5);

    // five TMS=1 clocks from Shift-IR
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1);
      if (i == 3) check("tms_rst_4th", 64'(RESET), 64'd0);
    end
    check("tms_rst_5th", 64'(RESET), 64'd1);
    model_ir = IR_RST_M;
    check("tms_rst_sel", 64'({SEL1, SEL2}), 64'd0);
    step(0, 0);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0: op = OP_U1;
        1: op = OP_U2;
        2: op = OP_BYP;
        3: op = OP_ID;
        default: op = 5'($urandom);
      endcase
      ir_scan(op);
      n = $urandom_range(1, 40);
      pause_at = ($urandom_range(0, 1) == 1 && n > 2) ? $urandom_range(0, n - 2) : -1;
      din = {$urandom, $urandom};
      usr = {$urandom, $urandom};
      dr_scan(n, din, usr, pause_at, dout);
    end

    // asynchronous reset in the middle of a USER1 Shift-DR
    ir_scan(OP_U1);
    step(1, 0); step(0, 0); step(0, 0); step(0, 1);
    check("mid_shift_drck_low", 64'(DRCK1), 64'd0);
    RST_B = 1'b0;
    #1;
    check("mid_rst_reset", 64'(RESET), 64'd1);
    check("mid_rst_sel", 64'({SEL1, SEL2}), 64'd0);
    check("mid_rst_drck", 64'({DRCK1, DRCK2}), 64'd3);
    check("mid_rst_tdo", 64'({TDO, TDO_OE}), 64'd0);
    @(negedge TCK); #2;
    RST_B = 1'b1;
    step(0, 0);
    model_ir = IR_RST_M;
    dr_scan(12, {$urandom, $urandom}, {$urandom, $urandom}, -1, dout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
